// File: rtl/led_fill_top.sv
// Bar-graph fill sequencer: after the first button press, one more LED lights per clock
// from bit 0 upward until all are lit, then holds until reset.
module led_fill_top #(
  parameter int unsigned WIDTH   = 16,
  parameter bit          ONE_HOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  output logic [WIDTH-1:0] led
);

  logic start_q, start_d;
  logic advance;

  // The raw button joins the sticky flag so the press edge itself already advances.
  always_comb begin
    start_d = start_q | button;
    advance = start_q | button;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_d;
    end
  end

  if (ONE_HOT) begin : g_one_hot
    localparam logic [WIDTH:0] SumOne = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] sum_q, sum_d;

    // A set top bit means every LED is lit; the hot bit stops there.
    always_comb begin
      sum_d = sum_q;
      if (advance && !sum_q[WIDTH]) begin
        sum_d = sum_q << 1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= SumOne;
      end else begin
        sum_q <= sum_d;
      end
    end

    assign led = WIDTH'(sum_q - SumOne);
  end else begin : g_therm
    logic [WIDTH-1:0] therm_q, therm_d;

    // Shifting a 1 into an all-ones vector leaves it unchanged, which gives saturation.
    always_comb begin
      therm_d = therm_q;
      if (advance) begin
        therm_d = (therm_q << 1) | WIDTH'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        therm_q <= '0;
      end else begin
        therm_q <= therm_d;
      end
    end

    assign led = therm_q;
  end

endmodule

// File: tb/tb_led_fill_top.sv
// Bench for led_fill_top: thermometer and one-hot variants at WIDTH=16 plus a WIDTH=4 copy,
// all driven by the same clk/rst/button and scored against a counting model.
module tb_led_fill_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button = 1'b0;
  logic [15:0] led16;
  logic [15:0] led16h;
  logic [3:0]  led4;

  always #5 clk = ~clk;

  led_fill_top u_dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .led    (led16)
  );

  led_fill_top #(.WIDTH(16), .ONE_HOT(1'b1)) u_dut_oh (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .led    (led16h)
  );

  led_fill_top #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .led    (led4)
  );

  typedef struct {
    logic [15:0] e16;
    logic [3:0]  e4;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_k = 0;
  bit   m_start = 1'b0;

  // Model: led after k advancing edges is 2^k - 1, capped at all ones.
  function automatic logic [15:0] therm16(input int k);
    logic [31:0] v;
    if (k >= 16) return 16'hFFFF;
    v = (32'd1 << k) - 32'd1;
    return v[15:0];
  endfunction

  function automatic logic [3:0] therm4(input int k);
    logic [31:0] v;
    if (k >= 4) return 4'hF;
    v = (32'd1 << k) - 32'd1;
    return v[3:0];
  endfunction

  // Scoreboard: one expectation is consumed per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests++;
      if (led16 !== e.e16) begin
        fails++;
        $display("FAIL sb_therm16: led=%h expected %h at %0t", led16, e.e16, $time);
      end
      tests++;
      if (led16h !== e.e16) begin
        fails++;
        $display("FAIL sb_onehot16: led=%h expected %h at %0t", led16h, e.e16, $time);
      end
      tests++;
      if (led4 !== e.e4) begin
        fails++;
        $display("FAIL sb_therm4: led=%h expected %h at %0t", led4, e.e4, $time);
      end
    end
  end

  // Called just after a falling edge: drive button, predict the next edge, wait a cycle.
  task automatic step(input logic b);
    button = b;
    if ((m_start || b) && m_k < 64) m_k++;
    if (b) m_start = 1'b1;
    sb_q.push_back('{e16: therm16(m_k), e4: therm4(m_k)});
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset(input logic b);
    button = b;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (led16 !== 16'h0 || led16h !== 16'h0 || led4 !== 4'h0) begin
      fails++;
      $display("FAIL async_reset: led16=%h led16h=%h led4=%h expected 0", led16, led16h, led4);
    end
    sb_q.delete();
    m_k = 0;
    m_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      button = i[0];
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (led16 !== 16'h0 || led16h !== 16'h0 || led4 !== 4'h0) begin
        fails++;
        $display("FAIL reset_hold: button=%b led16=%h led16h=%h led4=%h expected 0",
                 button, led16, led16h, led4);
      end
    end
  endtask

  task automatic test_continuous;
    logic [15:0] want;
    do_reset(1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1);
      want = 16'hxxxx;
      case (i)
        1:  want = 16'h0001;
        2:  want = 16'h0003;
        3:  want = 16'h0007;
        8:  want = 16'h00FF;
        16: want = 16'hFFFF;
        default: ;
      endcase
      if (i inside {1, 2, 3, 8, 16}) begin
        tests++;
        if (led16 !== want) begin
          fails++;
          $display("FAIL continuous_edge%0d: led=%h expected %h", i, led16, want);
        end
      end
      if (i == 4) begin
        tests++;
        if (led4 !== 4'hF) begin
          fails++;
          $display("FAIL width4_full: led=%h expected f", led4);
        end
      end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) begin
      step(i[0]);
      tests++;
      if (led16 !== 16'hFFFF || led16h !== 16'hFFFF || led4 !== 4'hF) begin
        fails++;
        $display("FAIL saturation_%0d: led16=%h led16h=%h led4=%h expected ffff/ffff/f",
                 i, led16, led16h, led4);
      end
    end
  endtask

  task automatic test_no_start;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      tests++;
      if (led16 !== 16'h0) begin
        fails++;
        $display("FAIL no_start_%0d: led=%h expected 0000", i, led16);
      end
    end
    step(1'b1);
    tests++;
    if (led16 !== 16'h0001) begin
      fails++;
      $display("FAIL pulse_first: led=%h expected 0001", led16);
    end
    step(1'b0);
    step(1'b0);
    tests++;
    if (led16 !== 16'h0007) begin
      fails++;
      $display("FAIL pulse_sticky: led=%h expected 0007", led16);
    end
  endtask

  task automatic test_mid_fill_reset;
    for (int i = 0; i < 3; i++) step(1'b0);
    tests++;
    if (led16 !== 16'h003F) begin
      fails++;
      $display("FAIL mid_fill_pre: led=%h expected 003f", led16);
    end
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      tests++;
      if (led16 !== 16'h0 || led4 !== 4'h0) begin
        fails++;
        $display("FAIL start_cleared_%0d: led16=%h led4=%h expected 0", i, led16, led4);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 22; i++) step(i[1]);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_saturation();
    test_no_start();
    test_mid_fill_reset();
    test_back_to_back();
    @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_fill_top.md
Name: led_fill_top

Overview:
- LED "bar-graph fill" sequencer for a 16-LED board.
- After reset, all LEDs are off.
- Once started by the button, one additional LED lights per clock from bit 0 upward, forming a thermometer code.
- The block saturates with all LEDs lit and holds until reset. It sits directly between the board button/clock and the LED output pins.

Parameters:
- WIDTH, 16, number of LEDs (thermometer length). The port width of led equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- button  input  1  start request, sampled on rising clk. Level-sensitive, synchronous, no debounce inside the block.
- led  output  WIDTH  thermometer-coded LED drive; bit i lit = 1.

Behaviour:
- Reset: rst is asynchronous and active-high, and the block is clocked by clk.
  - While rst=1: led=0x0000, start flag=0, internal counter state at initial value.
  - Reset asserted mid-fill aborts immediately (asynchronous): led goes to 0x0000 without waiting for a clock edge.
- Start flag:
  - Sticky register; set to 1 on any rising clk where button=1.
  - Cleared only by rst.
  - Further button activity after start has no effect.
- Advance condition:
  - advance = start_flag OR button, combinational.
  - If button=1 on the first edge after reset, the fill starts on that same edge; the start flag register adds no extra cycle of latency.
- State:
  - Implementation may use a one-hot register sum of WIDTH+1 bits, reset value 1, with led = sum - 1 (truncated to WIDTH bits).
  - Equivalently, a WIDTH-bit thermometer register, reset 0, shifting in 1 at bit 0.
  - Both forms must produce identical led values.
- Per rising clk with advance=1 and not saturated:
  - led <= (led << 1) | 1, i.e. led = 2^k - 1 after k advancing edges.
- Saturation: once led = all ones (2^WIDTH - 1, i.e. sum = 1<<WIDTH), led holds that value on every subsequent edge regardless of button.
- With advance=0 (not started, button low): led holds at 0x0000.
- Start and advance interaction:
  - The fill never pauses once started, even if button later goes low, because the sticky flag keeps advance=1.
  - The fill never decrements or wraps.
- Output timing:
  - led is a pure function of registered state, with no combinational path from button to led.
  - Output changes only on rising clk edges or on rst assertion.
- Sequence for WIDTH=16 with button held high from reset release:
  - Edges 1..16 give 0x0001, 0x0003, 0x0007, ..., 0x7FFF, 0xFFFF.
  - From edge 16 onward: 0xFFFF.
- Arithmetic: the one-hot form uses WIDTH+1 bits so that 1<<WIDTH is representable. The subtraction is modulo 2^(WIDTH+1) and is truncated to WIDTH bits for led.

Test Plan:
- Reset check: rst=1 with any button level -> led=0x0000. Assert rst asynchronously between edges -> led=0x0000 immediately.
- Continuous button: release rst, hold button=1 -> led after edges 1,2,3,8,16 = 0x0001, 0x0003, 0x0007, 0x00FF, 0xFFFF.
- Saturation: continue 20 more edges after edge 16 -> led stays 0xFFFF; toggle button -> still 0xFFFF.
- No start: release rst, button=0 for 10 edges -> led=0x0000 throughout. Then button=1 for one edge only -> led=0x0001; next edges 0x0003, 0x0007 continue with button=0.
- Mid-fill reset: after led=0x003F, pulse rst -> led=0x0000. Release rst with button=0 -> led stays 0x0000 (start flag cleared).
- Parameter check: WIDTH=4 with button held -> 0x1, 0x3, 0x7, 0xF, then hold at 0xF.
